calculator_input: RTL and testbench
===================================

# calculator_input

Operand-entry controller for the simple calculator: turns the raw board buttons into debounced single-cycle presses and edits the A and B operand registers bit-by-bit under a movable cursor. It also selects the operation and computes the registered answer. It is the writer for the VGA output stage, which reads `a_val`, `b_val`, `ans_val`, `cursor_pos` and `field_sel` to draw the three rows.

## Interface
- `WIDTH`, 16: operand width; one displayed digit per bit, position 0 is the leftmost digit (bit WIDTH-1).
- `DB_CNT`, 1_000_000: debounce stability count in clocks (10 ms at 100 MHz); benches use 4.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: asynchronous, active-low reset.
- `up`, `down`, `left`, `right`, `center` input 1 each: raw, asynchronous push-button levels, active-high.
- `a_val` output WIDTH: operand A.
- `b_val` output WIDTH: operand B.
- `ans_val` output WIDTH: result register.
- `ofl` output 1: carry-out (ADD) or borrow (SUB) of last computation; 0 for AND/OR.
- `ans_valid` output 1: high while in SHOW_ANS.
- `cursor_pos` output log2(WIDTH): current digit position.
- `field_sel` output 2: current state encoding, for row highlighting.
- `op` output 2: selected operation.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debouncer accepts a new level after DB_CNT consecutive identical samples. It emits a 1-cycle press pulse on an accepted 0->1 transition only.
- If several pulses occur in one cycle, only the highest-priority one acts: center > up > down > left > right. The others are dropped, not queued.
- States are EDIT_A (0), EDIT_B (1), SEL_OP (2) and SHOW_ANS (3).
- Center press advances the state in this order: EDIT_A -> EDIT_B -> SEL_OP -> SHOW_ANS -> EDIT_A.
- Every center press resets `cursor_pos` to 0.
- In EDIT_A and EDIT_B:
  - up sets the bit at the cursor to 1; down clears it to 0. The bit index is WIDTH-1-cursor_pos.
  - right increments `cursor_pos`, wrapping from WIDTH-1 to 0.
  - left decrements `cursor_pos`, wrapping from 0 to WIDTH-1.
- In SEL_OP:
  - up cycles `op` forward ADD(0) -> SUB(1) -> AND(2) -> OR(3) -> ADD; down cycles it backward.
  - left and right are ignored.
- On the SEL_OP -> SHOW_ANS transition, `ans_val` and `ofl` are loaded from `a_val op b_val`.
  - ADD: WIDTH+1-bit sum; `ofl` = MSB.
  - SUB: unsigned a-b modulo 2^WIDTH; `ofl` = (a < b).
- In SHOW_ANS, up, down, left and right are ignored. `ans_val` holds until the next computation.
- A and B are retained when the state wraps back to EDIT_A.

## Timing
- Reset values (asynchronous): all operands, `ans_val`, `ofl`, `ans_valid`, `cursor_pos` and `op` = 0; state = EDIT_A.
- Debouncer and synchronizer state is cleared to 0 on reset. A button held through reset release therefore yields one press after debounce.
- Press latency: a raw level held stable produces its pulse exactly DB_CNT+3 rising edges after the first edge that samples it high.
- Release latency: the same DB_CNT+3 edges; no pulse is emitted on release.
- Glitches shorter than DB_CNT cycles produce no pulse.
- The action for a pulse is visible on all outputs at the edge following the pulse cycle. All outputs are registered.
- `ans_valid` rises in the same cycle the loaded `ans_val` appears.
- Reset asserted mid-debounce or mid-edit discards everything immediately; no partial update survives.

## Structure
- Package `calc_pkg` holds:
  - the state enum (EDIT_A, EDIT_B, SEL_OP, SHOW_ANS);
  - the op enum (ADD, SUB, AND, OR);
  - the default WIDTH.
- Sub-module `button_debounce` contains the synchronizer, counter, accepted level and rising-edge pulse. It is parameterized by DB_CNT and instantiated five times.
- The top level holds the priority select, the FSM, the operand and cursor registers, and the ALU/answer register.

## Test plan
- Reset, then 3-cycle up glitch with DB_CNT=4 -> no pulse; `a_val` stays 0x0000.
- In EDIT_A, press up, right, up -> `a_val` = 0xC000 and `cursor_pos` = 1. Then left from 0 -> `cursor_pos` = 15.
- Center -> `field_sel` = 1, `cursor_pos` = 0. Set B position 15 -> `b_val` = 0x0001.
- With A=0xFFFF, B=0x0001: center, ADD, center -> `ans_val` = 0x0000, `ofl` = 1, `ans_valid` = 1.
- With A=0x0003, B=0x0005: op SUB via up -> `ans_val` = 0xFFFE, `ofl` = 1. From ADD, down -> `op` = OR.
- Up and left pulses in the same cycle -> only the up action occurs. Reset asserted mid-press -> all outputs 0 and state EDIT_A on the same edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator operand-entry block.
// State and operation encodings are also the VGA-visible codes.
package calc_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    EDIT_A   = 2'd0,
    EDIT_B   = 2'd1,
    SEL_OP   = 2'd2,
    SHOW_ANS = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } op_t;

endpackage

// File: rtl/button_debounce.sv
// Raw button to single-cycle press pulse.
// Sync, stability counter, accepted level, rising-edge pulse.
module button_debounce #(
  parameter int DB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // any sample matching the accepted level restarts the count
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calculator_input.sv
// Calculator operand entry: debounced buttons drive a cursor
// editor for A/B, an op selector and the registered answer.
module calculator_input
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DB_CNT = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  input  logic                     center,
  output logic [WIDTH-1:0]         a_val,
  output logic [WIDTH-1:0]         b_val,
  output logic [WIDTH-1:0]         ans_val,
  output logic                     ofl,
  output logic                     ans_valid,
  output logic [$clog2(WIDTH)-1:0] cursor_pos,
  output logic [1:0]               field_sel,
  output logic [1:0]               op
);

  localparam int CW = $clog2(WIDTH);

  logic p_up, p_down, p_left, p_right, p_center;

  button_debounce #(.DB_CNT(DB_CNT)) u_db_up (
    .clk(clk), .rst(rst), .raw(up), .pulse(p_up)
  );
  button_debounce #(.DB_CNT(DB_CNT)) u_db_down (
    .clk(clk), .rst(rst), .raw(down), .pulse(p_down)
  );
  button_debounce #(.DB_CNT(DB_CNT)) u_db_left (
    .clk(clk), .rst(rst), .raw(left), .pulse(p_left)
  );
  button_debounce #(.DB_CNT(DB_CNT)) u_db_right (
    .clk(clk), .rst(rst), .raw(right), .pulse(p_right)
  );
  button_debounce #(.DB_CNT(DB_CNT)) u_db_center (
    .clk(clk), .rst(rst), .raw(center), .pulse(p_center)
  );

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             ofl_q, ofl_d;
  logic             valid_q;
  logic [CW-1:0]    cur_q, cur_d;
  logic [CW-1:0]    idx;
  logic [WIDTH:0]   alu;
  logic             editing;

  // cursor 0 is the leftmost digit, i.e. the MSB
  assign idx     = CW'(WIDTH - 1) - cur_q;
  assign editing = (state_q == EDIT_A) || (state_q == EDIT_B);

  always_comb begin
    alu = '0;
    unique case (op_q)
      ADD:     alu = {1'b0, a_q} + {1'b0, b_q};
      SUB:     alu = {1'b0, a_q} - {1'b0, b_q};
      AND:     alu = {1'b0, a_q & b_q};
      OR:      alu = {1'b0, a_q | b_q};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EDIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    ans_d   = ans_q;
    ofl_d   = ofl_q;
    cur_d   = cur_q;
    priority case (1'b1)
      p_center: begin
        cur_d = '0;
        unique case (state_q)
          EDIT_A:   state_d = EDIT_B;
          EDIT_B:   state_d = SEL_OP;
          SEL_OP: begin
            state_d = SHOW_ANS;
            ans_d   = alu[WIDTH-1:0];
            ofl_d   = alu[WIDTH];
          end
          default:  state_d = EDIT_A;
        endcase
      end
      p_up: begin
        if (state_q == EDIT_A) a_d[idx] = 1'b1;
        if (state_q == EDIT_B) b_d[idx] = 1'b1;
        if (state_q == SEL_OP) op_d = op_t'(op_q + 2'd1);
      end
      p_down: begin
        if (state_q == EDIT_A) a_d[idx] = 1'b0;
        if (state_q == EDIT_B) b_d[idx] = 1'b0;
        if (state_q == SEL_OP) op_d = op_t'(op_q - 2'd1);
      end
      p_left: begin
        if (editing) begin
          cur_d = (cur_q == '0) ? CW'(WIDTH - 1) : cur_q - 1'b1;
        end
      end
      p_right: begin
        if (editing) begin
          cur_d = (cur_q == CW'(WIDTH - 1)) ? '0 : cur_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= ADD;
      a_q     <= '0;
      b_q     <= '0;
      ans_q   <= '0;
      ofl_q   <= 1'b0;
      valid_q <= 1'b0;
      cur_q   <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ans_q   <= ans_d;
      ofl_q   <= ofl_d;
      valid_q <= (state_d == SHOW_ANS);
      cur_q   <= cur_d;
    end
  end

  assign a_val      = a_q;
  assign b_val      = b_q;
  assign ans_val    = ans_q;
  assign ofl        = ofl_q;
  assign ans_valid  = valid_q;
  assign cursor_pos = cur_q;
  assign field_sel  = state_q;
  assign op         = op_q;

endmodule

// File: tb/tb_calculator_input.sv
// Bench for calculator_input: directed plan items plus random
// button traffic scored against a transaction-level model.
module tb_calculator_input;

  localparam int W  = 16;
  localparam int DB = 4;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         up = 1'b0, down = 1'b0, left = 1'b0;
  logic         right = 1'b0, center = 1'b0;
  logic [W-1:0] a_val, b_val, ans_val;
  logic         ofl, ans_valid;
  logic [3:0]   cursor_pos;
  logic [1:0]   field_sel, op;

  int n_cmp = 0;
  int n_bad = 0;

  int m_a, m_b, m_ans, m_ofl, m_cur, m_op, m_st;

  calculator_input #(.WIDTH(W), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst),
    .up(up), .down(down), .left(left), .right(right),
    .center(center),
    .a_val(a_val), .b_val(b_val), .ans_val(ans_val),
    .ofl(ofl), .ans_valid(ans_valid),
    .cursor_pos(cursor_pos), .field_sel(field_sel), .op(op)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_ans = 0; m_ofl = 0;
    m_cur = 0; m_op = 0; m_st = 0;
  endtask

  task automatic model_apply(input logic [4:0] m);
    int r;
    if (m[4]) begin
      m_cur = 0;
      if (m_st == 2) begin
        case (m_op)
          0: begin
            r = m_a + m_b;
            m_ans = r % 65536;
            m_ofl = r / 65536;
          end
          1: begin
            m_ans = (m_a - m_b + 65536) % 65536;
            m_ofl = (m_a < m_b) ? 1 : 0;
          end
          2: begin m_ans = m_a & m_b; m_ofl = 0; end
          default: begin m_ans = m_a | m_b; m_ofl = 0; end
        endcase
      end
      m_st = (m_st + 1) % 4;
    end else if (m[3]) begin
      if (m_st == 0) m_a = m_a | (1 << (15 - m_cur));
      if (m_st == 1) m_b = m_b | (1 << (15 - m_cur));
      if (m_st == 2) m_op = (m_op + 1) % 4;
    end else if (m[2]) begin
      if (m_st == 0) m_a = m_a & ~(1 << (15 - m_cur));
      if (m_st == 1) m_b = m_b & ~(1 << (15 - m_cur));
      if (m_st == 2) m_op = (m_op + 3) % 4;
    end else if (m[1]) begin
      if (m_st < 2) m_cur = (m_cur + 15) % 16;
    end else if (m[0]) begin
      if (m_st < 2) m_cur = (m_cur + 1) % 16;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"},     32'(a_val),      32'(m_a));
    check({tag, ".b"},     32'(b_val),      32'(m_b));
    check({tag, ".ans"},   32'(ans_val),    32'(m_ans));
    check({tag, ".ofl"},   32'(ofl),        32'(m_ofl));
    check({tag, ".valid"}, 32'(ans_valid),  32'(m_st == 3));
    check({tag, ".cur"},   32'(cursor_pos), 32'(m_cur));
    check({tag, ".fsel"},  32'(field_sel),  32'(m_st));
    check({tag, ".op"},    32'(op),         32'(m_op));
  endtask

  task automatic drive(input logic [4:0] m);
    {center, up, down, left, right} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(negedge clk);
    drive(m);
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (DB + 6) @(negedge clk);
    if (hold >= DB) model_apply(m);
  endtask

  task automatic write_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      press(w[15-i] ? BU : BD, DB);
      press(BR, DB);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [4:0] m;
    int         hold;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all("reset");

    press(BU, 3);
    check("glitch.a", 32'(a_val), 32'h0);
    check_all("glitch");

    press(BU, DB); press(BR, DB); press(BU, DB);
    check("plan.a", 32'(a_val), 32'hC000);
    check("plan.cur1", 32'(cursor_pos), 32'd1);
    press(BL, DB); press(BL, DB);
    check("plan.cur15", 32'(cursor_pos), 32'd15);
    press(BC, DB);
    check("plan.fsel", 32'(field_sel), 32'd1);
    check("plan.cur0", 32'(cursor_pos), 32'd0);
    press(BL, DB); press(BU, DB);
    check("plan.b", 32'(b_val), 32'h0001);
    check_all("edit");

    do_reset();
    write_word(16'hFFFF);
    press(BC, DB);
    write_word(16'h0001);
    press(BC, DB); press(BC, DB);
    check("add.ans", 32'(ans_val), 32'h0000);
    check("add.ofl", 32'(ofl), 32'd1);
    check("add.valid", 32'(ans_valid), 32'd1);
    check_all("add");

    press(BC, DB);
    write_word(16'h0003);
    press(BC, DB);
    write_word(16'h0005);
    press(BC, DB); press(BU, DB);
    check("sub.op", 32'(op), 32'd1);
    press(BC, DB);
    check("sub.ans", 32'(ans_val), 32'hFFFE);
    check("sub.ofl", 32'(ofl), 32'd1);
    check_all("sub");

    press(BC, DB); press(BC, DB); press(BC, DB);
    press(BD, DB);
    check("down.add", 32'(op), 32'd0);
    press(BD, DB);
    check("down.or", 32'(op), 32'd3);
    press(BC, DB); press(BC, DB);
    check_all("or");

    press(BU | BL, DB);
    check("prio.a", 32'(a_val), 32'h8003);
    check("prio.cur", 32'(cursor_pos), 32'd0);
    check_all("prio");

    @(negedge clk);
    drive(BU);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("midrst");
    @(negedge clk);
    drive(5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (DB + 6) @(negedge clk);
    check_all("postrst");

    @(negedge clk);
    drive(BU);
    repeat (DB + 3) @(posedge clk);
    #1 check("lat.early", 32'(a_val), 32'h0);
    @(posedge clk);
    #1 check("lat.edge", 32'(a_val), 32'h8000);
    @(negedge clk);
    drive(5'b0);
    repeat (DB + 6) @(negedge clk);
    model_apply(BU);
    check_all("lat");

    for (int i = 0; i < 200; i++) begin
      m = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) m = m | 5'(1 << $urandom_range(0, 4));
      hold = $urandom_range(1, DB + 3);
      press(m, hold);
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
